// File: rtl/sm4_key_expand_ctrl.sv
// SM4 key-schedule controller: expands a 128-bit master key into 32 round
// keys (one per cycle) and serves them by index in forward or reverse order.

// Round constant CK[i]: byte j of CK[i] is (4*i + j) * 7 mod 256.
module SM4_KEY_CKI (
    input  logic [4:0]  round_i,
    output logic [31:0] ck_o
);
    for (genvar j = 0; j < 4; j++) begin : g_ck
        logic [7:0] ck_idx;
        assign ck_idx = {1'b0, round_i, 2'(j)};
        assign ck_o[8*(3-j) +: 8] = ck_idx * 8'd7;
    end
endmodule

// SM4 byte substitution; entry 0 sits in the top byte of the table.
module sm4_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [2047:0] SBOX_TBL = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Bit offset of entry x is 8*(255-x), i.e. {~x, 3'b000}.
    assign out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];
endmodule

module sm4_key_expand_ctrl (
    input  logic         clk_sys,
    input  logic         rst_sys,
    input  logic         key_start,
    input  logic [127:0] key_in,
    input  logic [4:0]   rk_rd_idx,
    input  logic         rk_dec,
    output logic         key_busy,
    output logic         key_ready,
    output logic [4:0]   sm4_round_cnt,
    output logic [31:0]  rk_out
);
    localparam logic [31:0] FK0 = 32'ha3b1bac6;
    localparam logic [31:0] FK1 = 32'h56aa3350;
    localparam logic [31:0] FK2 = 32'h677d9197;
    localparam logic [31:0] FK3 = 32'hb27022dc;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] k0_q, k1_q, k2_q, k3_q;
    logic [31:0] k0_d, k1_d, k2_d, k3_d;
    logic [31:0] rkfile_q [32];
    logic        wr_en;

    logic [31:0] ck;
    logic [31:0] t_in;
    logic [31:0] tau;
    logic [31:0] l_out;
    logic [31:0] rk_new;
    logic [4:0]  rd_idx;

    SM4_KEY_CKI u_cki (
        .round_i (sm4_round_cnt),
        .ck_o    (ck)
    );

    assign t_in = k1_q ^ k2_q ^ k3_q ^ ck;

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        sm4_sbox u_sbox (
            .in_i  (t_in[8*j +: 8]),
            .out_o (tau[8*j +: 8])
        );
    end

    assign l_out  = tau ^ {tau[18:0], tau[31:19]} ^ {tau[8:0], tau[31:9]};
    assign rk_new = k0_q ^ l_out;

    // Next-state, counter and key-window update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        wr_en   = 1'b0;
        unique case (state_q)
            EXPAND: begin
                wr_en = 1'b1;
                k0_d  = k1_q;
                k1_d  = k2_q;
                k2_d  = k3_q;
                k3_d  = rk_new;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                if (key_start) begin
                    k0_d    = key_in[127:96] ^ FK0;
                    k1_d    = key_in[95:64]  ^ FK1;
                    k2_d    = key_in[63:32]  ^ FK2;
                    k3_d    = key_in[31:0]   ^ FK3;
                    cnt_d   = '0;
                    state_d = EXPAND;
                end
            end
        endcase
    end

    // State, counter and key-window registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
        end
    end

    // Round-key file; unreset because reads are gated by key_ready.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            rkfile_q[cnt_q] <= rk_new;
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        key_busy      = 1'b0;
        key_ready     = 1'b0;
        sm4_round_cnt = '0;
        unique case (state_q)
            EXPAND: begin
                key_busy      = 1'b1;
                sm4_round_cnt = cnt_q;
            end
            DONE: begin
                key_ready     = 1'b1;
                sm4_round_cnt = 5'd31;
            end
            default: ;
        endcase
    end

    assign rd_idx = rk_dec ? (5'd31 - rk_rd_idx) : rk_rd_idx;

    // Combinational round-key read, forced to zero until expansion completes.
    always_comb begin
        rk_out = '0;
        if (key_ready) begin
            rk_out = rkfile_q[rd_idx];
        end
    end
endmodule

// File: tb/tb_sm4_key_expand_ctrl.sv
// Self-checking bench for sm4_key_expand_ctrl against a software key schedule.
module tb_sm4_key_expand_ctrl;
    logic         clk_sys = 1'b0;
    logic         rst_sys;
    logic         key_start;
    logic [127:0] key_in;
    logic [4:0]   rk_rd_idx;
    logic         rk_dec;
    logic         key_busy;
    logic         key_ready;
    logic [4:0]   sm4_round_cnt;
    logic [31:0]  rk_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_rk [32];

    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [31:0]  FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    localparam logic [2047:0] SBOX_TBL = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    sm4_key_expand_ctrl dut (
        .clk_sys       (clk_sys),
        .rst_sys       (rst_sys),
        .key_start     (key_start),
        .key_in        (key_in),
        .rk_rd_idx     (rk_rd_idx),
        .rk_dec        (rk_dec),
        .key_busy      (key_busy),
        .key_ready     (key_ready),
        .sm4_round_cnt (sm4_round_cnt),
        .rk_out        (rk_out)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 1000000)", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_TBL >> (8 * (255 - int'(x)));
        return t[7:0];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Plain software SM4 key schedule filling ref_rk.
    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [4];
        logic [31:0] ck, x, b, rk;
        for (int w = 0; w < 4; w++) k[w] = mk[127 - 32*w -: 32] ^ FK[w];
        for (int i = 0; i < 32; i++) begin
            ck = '0;
            for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4*i + j) * 7) % 256)};
            x  = k[1] ^ k[2] ^ k[3] ^ ck;
            b  = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
            rk = k[0] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
            ref_rk[i] = rk;
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = rk;
        end
    endtask

    task automatic start_key(input logic [127:0] k);
        @(negedge clk_sys);
        key_start = 1'b1;
        key_in    = k;
        @(posedge clk_sys);
        #1;
        key_start = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic read_rk(input logic [4:0] idx, input logic dec, output logic [31:0] v);
        @(negedge clk_sys);
        rk_rd_idx = idx;
        rk_dec    = dec;
        #1;
        v = rk_out;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_sys);
            if (key_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst_sys   = 1'b1;
        key_start = 1'b0;
        key_in    = '0;
        rk_rd_idx = 5'($urandom_range(0, 31));
        rk_dec    = 1'($urandom);
        repeat (2) @(posedge clk_sys);
        #1;
        n_checks++;
        if (key_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", key_busy); end
        n_checks++;
        if (key_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", key_ready); end
        n_checks++;
        if (sm4_round_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", sm4_round_cnt); end
        n_checks++;
        if (rk_out !== 32'h0) begin n_fail++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
        @(negedge clk_sys);
        rst_sys = 1'b0;
    endtask

    task automatic test_standard;
        logic [31:0] v;
        logic [4:0]  idx;
        logic        dec;
        model_expand(STD_KEY);
        start_key(STD_KEY);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_sys);
            n_checks++;
            if (key_busy !== 1'b1 || sm4_round_cnt !== 5'(i)) begin
                n_fail++;
                $display("FAIL std_expand_cycle%0d: busy=%b cnt=%0d want busy=1 cnt=%0d", i, key_busy, sm4_round_cnt, i);
            end
        end
        @(negedge clk_sys);
        n_checks++;
        if (key_busy !== 1'b0 || key_ready !== 1'b1 || sm4_round_cnt !== 5'd31) begin
            n_fail++;
            $display("FAIL std_done: busy=%b ready=%b cnt=%0d want 0 1 31", key_busy, key_ready, sm4_round_cnt);
        end
        read_rk(5'd0, 1'b0, v);
        n_checks++;
        if (v !== 32'hf12186f9) begin n_fail++; $display("FAIL std_rk0: got %h want f12186f9", v); end
        read_rk(5'd1, 1'b0, v);
        n_checks++;
        if (v !== 32'h41662b61) begin n_fail++; $display("FAIL std_rk1: got %h want 41662b61", v); end
        read_rk(5'd31, 1'b0, v);
        n_checks++;
        if (v !== 32'h9124a012) begin n_fail++; $display("FAIL std_rk31: got %h want 9124a012", v); end
        for (int i = 0; i < 32; i++) begin
            idx = 5'($urandom_range(0, 31));
            dec = 1'($urandom);
            read_rk(idx, dec, v);
            n_checks++;
            if (v !== ref_rk[dec ? 31 - int'(idx) : int'(idx)]) begin
                n_fail++;
                $display("FAIL std_random_read idx=%0d dec=%b: got %h want %h", idx, dec, v,
                         ref_rk[dec ? 31 - int'(idx) : int'(idx)]);
            end
        end
    endtask

    task automatic test_decrypt;
        logic [31:0] v;
        read_rk(5'd0, 1'b1, v);
        n_checks++;
        if (v !== 32'h9124a012) begin n_fail++; $display("FAIL dec_idx0: got %h want 9124a012", v); end
        read_rk(5'd31, 1'b1, v);
        n_checks++;
        if (v !== 32'hf12186f9) begin n_fail++; $display("FAIL dec_idx31: got %h want f12186f9", v); end
        for (int i = 0; i < 32; i++) begin
            read_rk(5'(i), 1'b1, v);
            n_checks++;
            if (v !== ref_rk[31 - i]) begin
                n_fail++;
                $display("FAIL dec_order idx=%0d: got %h want %h", i, v, ref_rk[31 - i]);
            end
        end
    endtask

    task automatic test_ignored_start;
        logic [31:0] v;
        @(negedge clk_sys);
        rst_sys = 1'b1;
        @(negedge clk_sys);
        rst_sys = 1'b0;
        model_expand(STD_KEY);
        start_key(STD_KEY);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_sys);
            n_checks++;
            if (key_busy !== 1'b1 || sm4_round_cnt !== 5'(i)) begin
                n_fail++;
                $display("FAIL ign_cycle%0d: busy=%b cnt=%0d want busy=1 cnt=%0d", i, key_busy, sm4_round_cnt, i);
            end
            if (i == 10 || i == 31) begin
                key_start = 1'b1;
                key_in    = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                key_start = 1'b0;
            end
        end
        @(negedge clk_sys);
        key_start = 1'b0;
        n_checks++;
        if (key_ready !== 1'b1 || key_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_done: ready=%b busy=%b want 1 0", key_ready, key_busy);
        end
        @(negedge clk_sys);
        n_checks++;
        if (key_ready !== 1'b1 || sm4_round_cnt !== 5'd31) begin
            n_fail++;
            $display("FAIL ign_hold_done: ready=%b cnt=%0d want 1 31", key_ready, sm4_round_cnt);
        end
        for (int i = 0; i < 32; i++) begin
            read_rk(5'(i), 1'b0, v);
            n_checks++;
            if (v !== ref_rk[i]) begin
                n_fail++;
                $display("FAIL ign_keys idx=%0d: got %h want %h", i, v, ref_rk[i]);
            end
        end
    endtask

    task automatic test_rekey;
        logic [31:0]  v;
        logic [127:0] k;
        for (int r = 0; r < 4; r++) begin
            k = (r == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            start_key(k);
            n_checks++;
            if (key_ready !== 1'b0 || key_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rekey%0d_drop_ready: ready=%b busy=%b want 0 1", r, key_ready, key_busy);
            end
            for (int c = 1; c < 32; c++) begin
                @(posedge clk_sys);
                #1;
                n_checks++;
                if (key_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rekey%0d_busy cycle%0d: got %b want 1", r, c, key_busy);
                end
            end
            @(posedge clk_sys);
            #1;
            n_checks++;
            if (key_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rekey%0d_ready: got %b want 1", r, key_ready);
            end
            for (int i = 0; i < 32; i++) begin
                read_rk(5'(i), 1'b0, v);
                n_checks++;
                if (v !== ref_rk[i]) begin
                    n_fail++;
                    $display("FAIL rekey%0d_keys idx=%0d: got %h want %h", r, i, v, ref_rk[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0]  v;
        logic [127:0] k;
        bit           ok;
        start_key(STD_KEY);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys);
            if (i == 15) begin
                rst_sys   = 1'b1;
                rk_rd_idx = 5'($urandom_range(0, 31));
                rk_dec    = 1'($urandom);
            end
        end
        @(posedge clk_sys);
        #1;
        n_checks++;
        if (key_busy !== 1'b0 || key_ready !== 1'b0 || rk_out !== 32'h0 || sm4_round_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL midop_reset: busy=%b ready=%b rk=%h cnt=%0d want 0 0 0 0",
                     key_busy, key_ready, rk_out, sm4_round_cnt);
        end
        @(negedge clk_sys);
        rst_sys   = 1'b1;
        key_start = 1'b1;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk_sys);
        rst_sys   = 1'b0;
        key_start = 1'b0;
        @(posedge clk_sys);
        #1;
        n_checks++;
        if (key_busy !== 1'b0 || key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: busy=%b ready=%b want 0 0", key_busy, key_ready);
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        start_key(k);
        wait_ready(40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midop_fresh_timeout: key_ready=%b want 1 within 40 cycles", key_ready); end
        for (int i = 0; i < 32; i++) begin
            read_rk(5'(i), 1'($urandom), v);
            n_checks++;
            if (v !== ref_rk[rk_dec ? 31 - i : i]) begin
                n_fail++;
                $display("FAIL midop_fresh_keys idx=%0d dec=%b: got %h want %h", i, rk_dec, v,
                         ref_rk[rk_dec ? 31 - i : i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_decrypt();
        test_ignored_start();
        test_rekey();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
